// File: rtl/data_sync_pkg.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------------+
// | Module   : data_sync_pkg                                                   |
// | Purpose  : Shared helpers for the data_sync synchronizer slice. Holds no   |
// |            types or constants; every parameter stays local to the modules. |
// | Contents : stages_ok() - legality test for the synchronizer depth.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package data_sync_pkg;

    // Fewer than two flops gives no real MTBF margin. More than four adds
    // latency with no practical benefit at the clock rates this block serves.
    function automatic bit stages_ok(input int stages);
        return (stages >= 2) && (stages <= 4);
    endfunction

endpackage : data_sync_pkg
`default_nettype wire

// File: rtl/data_sync_sync_bit.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------------+
// | Module   : sync_bit                                                        |
// | Purpose  : One-bit multi-flop synchronizer chain into the clk_i domain.    |
// | Ports    : clk_i  in  1  destination clock, rising edge                    |
// |            rst_i  in  1  synchronous active-high reset                     |
// |            d_i    in  1  asynchronous input bit                            |
// |            q_o    out 1  synchronized bit, driven by the last chain flop   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sync_bit
    import data_sync_pkg::*;
#(
    parameter int   S_STAGES = 2,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    // The whole chain carries ASYNC_REG so placement keeps the flops adjacent
    // and retiming cannot move logic between them. Bit 0 is the capture flop.
    (* ASYNC_REG = "TRUE" *) logic [S_STAGES-1:0] chain;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain <= {S_STAGES{RST_BIT}};
        end else begin
            chain <= {chain[S_STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[S_STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/data_sync.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------------+
// | Module   : data_sync                                                       |
// | Purpose  : Per-bit multi-flop CDC synchronizer for a bus of independent,   |
// |            slowly changing bits, with rise/fall/change pulses generated in |
// |            the destination domain. Not a coherent bus transfer: bits may   |
// |            land one cycle apart.                                           |
// | Ports    : clk_i   in  1        destination clock, rising edge             |
// |            rst_i   in  1        synchronous active-high reset              |
// |            data_i  in  D_WIDTH  asynchronous input bus                     |
// |            data_o  out D_WIDTH  synchronized bus                           |
// |            rise_o  out D_WIDTH  1-cycle pulse on synchronized 0->1         |
// |            fall_o  out D_WIDTH  1-cycle pulse on synchronized 1->0         |
// |            chg_o   out D_WIDTH  rise_o | fall_o                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_sync
    import data_sync_pkg::*;
#(
    parameter int                 D_WIDTH  = 8,
    parameter int                 S_STAGES = 2,
    parameter logic [D_WIDTH-1:0] RST_VAL  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic [D_WIDTH-1:0] rise_o,
    output logic [D_WIDTH-1:0] fall_o,
    output logic [D_WIDTH-1:0] chg_o
);

    // Reject illegal configurations at elaboration time.
    if (D_WIDTH < 1) begin : g_bad_width
        $error("data_sync: D_WIDTH must be >= 1 (got %0d)", D_WIDTH);
    end
    if (!stages_ok(S_STAGES)) begin : g_bad_stages
        $error("data_sync: S_STAGES must be in 2..4 (got %0d)", S_STAGES);
    end

    logic [D_WIDTH-1:0] sync_q;
    logic [D_WIDTH-1:0] prev;

    // One independent chain per bit; no logic is shared between bits.
    for (genvar i = 0; i < D_WIDTH; i++) begin : g_bit
        sync_bit #(
            .S_STAGES (S_STAGES),
            .RST_BIT  (RST_VAL[i])
        ) u_sync_bit (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (data_i[i]),
            .q_o   (sync_q[i])
        );
    end

    // The history register resets to the same value as the chains, so neither
    // reset entry nor reset exit produces an edge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev <= RST_VAL;
        end else begin
            prev <= sync_q;
        end
    end

    assign data_o = sync_q;
    assign rise_o = sync_q & ~prev;
    assign fall_o = ~sync_q & prev;
    assign chg_o  = sync_q ^ prev;

endmodule : data_sync
`default_nettype wire

// File: tb/tb_data_sync.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------------+
// | Module   : tb_data_sync                                                    |
// | Purpose  : Self-checking bench for data_sync: default 8-bit/2-stage DUT    |
// |            and a 1-bit/3-stage/reset-high DUT on a shared 5 ns clock.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic [7:0] data_o, rise_o, fall_o, chg_o;
    logic       d3_i;
    logic       d3_o, rise3_o, fall3_o, chg3_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #2.5 clk = ~clk;

    data_sync dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data_i),
        .data_o (data_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .chg_o  (chg_o)
    );

    data_sync #(
        .D_WIDTH  (1),
        .S_STAGES (3),
        .RST_VAL  (1'b1)
    ) dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (d3_i),
        .data_o (d3_o),
        .rise_o (rise3_o),
        .fall_o (fall3_o),
        .chg_o  (chg3_o)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held 3 cycles with A5 on the input; outputs must sit at the reset
    // value with no pulses, then A5 appears exactly two edges after release.
    task automatic test_reset();
        rst    = 1'b1;
        data_i = 8'hA5;
        d3_i   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data cyc%0d: got %h want 00", c, data_o); end
            n_cmp++;
            if ({rise_o, fall_o, chg_o} !== 24'h0) begin n_mis++; $display("FAIL reset_pulses cyc%0d: got r%h f%h c%h want 0", c, rise_o, fall_o, chg_o); end
            n_cmp++;
            if ({d3_o, rise3_o, fall3_o, chg3_o} !== 4'b1000) begin n_mis++; $display("FAIL reset_p3 cyc%0d: got q%b r%b f%b c%b want q1 r0 f0 c0", c, d3_o, rise3_o, fall3_o, chg3_o); end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (data_o !== 8'h00 || chg_o !== 8'h00) begin n_mis++; $display("FAIL release_edge1: got d%h c%h want d00 c00", data_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'hA5) begin n_mis++; $display("FAIL release_edge2_data: got %h want a5", data_o); end
        n_cmp++;
        if (rise_o !== 8'hA5 || fall_o !== 8'h00 || chg_o !== 8'hA5) begin n_mis++; $display("FAIL release_edge2_pulse: got r%h f%h c%h want ra5 f00 ca5", rise_o, fall_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'hA5 || rise_o !== 8'h00 || chg_o !== 8'h00) begin n_mis++; $display("FAIL release_edge3: got d%h r%h c%h want da5 r00 c00", data_o, rise_o, chg_o); end
    endtask

    task automatic test_latency();
        data_i = 8'h00;
        repeat (4) tick();
        data_i = 8'h3C;
        tick();
        n_cmp++;
        if (data_o !== 8'h00 || chg_o !== 8'h00) begin n_mis++; $display("FAIL latency_edge1: got d%h c%h want d00 c00", data_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'h3C) begin n_mis++; $display("FAIL latency_edge2_data: got %h want 3c", data_o); end
        n_cmp++;
        if (rise_o !== 8'h3C || fall_o !== 8'h00 || chg_o !== 8'h3C) begin n_mis++; $display("FAIL latency_edge2_pulse: got r%h f%h c%h want r3c f00 c3c", rise_o, fall_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'h3C || {rise_o, fall_o, chg_o} !== 24'h0) begin n_mis++; $display("FAIL latency_edge3: got d%h r%h f%h c%h want d3c, no pulses", data_o, rise_o, fall_o, chg_o); end
    endtask

    task automatic test_mixed_edges();
        data_i = 8'hF0;
        repeat (3) tick();
        n_cmp++;
        if (data_o !== 8'hF0) begin n_mis++; $display("FAIL mixed_settle: got %h want f0", data_o); end
        data_i = 8'h0F;
        tick();
        tick();
        n_cmp++;
        if (data_o !== 8'h0F || rise_o !== 8'h0F || fall_o !== 8'hF0 || chg_o !== 8'hFF) begin
            n_mis++; $display("FAIL mixed_pulse: got d%h r%h f%h c%h want d0f r0f ff0 cff", data_o, rise_o, fall_o, chg_o);
        end
        tick();
        n_cmp++;
        if ({rise_o, fall_o, chg_o} !== 24'h0) begin n_mis++; $display("FAIL mixed_one_cycle: got r%h f%h c%h want 0", rise_o, fall_o, chg_o); end
    endtask

    // Input changes every 3 ns, offset so no change lands on a clock edge.
    // Model: a history of input values sampled at each rising edge. Each output
    // bit must match that bit of the input seen one or two edges before the
    // current one (the nominal value, or one cycle late). Edge outputs must
    // follow from consecutive observed data_o values.
    task automatic test_random();
        logic [7:0] hist [0:3];
        logic [7:0] s;
        logic [7:0] last_o;
        logic [7:0] bad;
        for (int i = 0; i < 4; i++) hist[i] = data_i;
        last_o = data_o;
        fork
            begin
                #0.5;
                repeat (64) begin
                    data_i = 8'($urandom);
                    #3;
                end
            end
            begin
                for (int c = 0; c < 44; c++) begin
                    @(posedge clk);
                    s = data_i;
                    #1;
                    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = s;
                    if (c >= 3) begin
                        bad = (data_o ^ hist[1]) & (data_o ^ hist[2]);
                        n_cmp++;
                        if (bad !== 8'h00) begin n_mis++; $display("FAIL rand_track cyc%0d: got %h want per-bit %h or %h", c, data_o, hist[1], hist[2]); end
                        n_cmp++;
                        if (chg_o !== (data_o ^ last_o) || rise_o !== (data_o & ~last_o) || fall_o !== (~data_o & last_o)) begin
                            n_mis++; $display("FAIL rand_edges cyc%0d: got r%h f%h c%h want r%h f%h c%h", c, rise_o, fall_o, chg_o,
                                              data_o & ~last_o, ~data_o & last_o, data_o ^ last_o);
                        end
                    end
                    last_o = data_o;
                end
            end
        join
    endtask

    // Reset lands while CC is in the chain: CC must never appear, reset entry
    // and exit produce no pulse, then 33 is tracked normally from RST_VAL.
    task automatic test_mid_reset();
        data_i = 8'h33;
        repeat (4) tick();
        data_i = 8'hCC;
        tick();
        rst    = 1'b1;
        data_i = 8'h33;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (data_o !== 8'h00 || {rise_o, fall_o, chg_o} !== 24'h0) begin n_mis++; $display("FAIL midrst_entry: got d%h r%h f%h c%h want d00, no pulses", data_o, rise_o, fall_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'h00 || {rise_o, fall_o, chg_o} !== 24'h0) begin n_mis++; $display("FAIL midrst_exit: got d%h r%h f%h c%h want d00, no pulses", data_o, rise_o, fall_o, chg_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'h33 || rise_o !== 8'h33 || fall_o !== 8'h00) begin n_mis++; $display("FAIL midrst_track: got d%h r%h f%h want d33 r33 f00", data_o, rise_o, fall_o); end
        tick();
        n_cmp++;
        if (data_o !== 8'h33 || chg_o !== 8'h00) begin n_mis++; $display("FAIL midrst_settled: got d%h c%h want d33 c00", data_o, chg_o); end
    endtask

    // Three-stage, one-bit, reset-high instance: latency is three edges.
    task automatic test_params();
        d3_i = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (d3_o !== 1'b1 || chg3_o !== 1'b0) begin n_mis++; $display("FAIL p3_settle: got q%b c%b want q1 c0", d3_o, chg3_o); end
        d3_i = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_cmp++;
            if (d3_o !== 1'b1 || chg3_o !== 1'b0) begin n_mis++; $display("FAIL p3_fall_edge%0d: got q%b c%b want q1 c0", e, d3_o, chg3_o); end
        end
        tick();
        n_cmp++;
        if ({d3_o, rise3_o, fall3_o, chg3_o} !== 4'b0011) begin n_mis++; $display("FAIL p3_fall_edge3: got q%b r%b f%b c%b want q0 r0 f1 c1", d3_o, rise3_o, fall3_o, chg3_o); end
        d3_i = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (d3_o !== 1'b0) begin n_mis++; $display("FAIL p3_rise_early: got q%b want q0", d3_o); end
        tick();
        n_cmp++;
        if ({d3_o, rise3_o, fall3_o, chg3_o} !== 4'b1101) begin n_mis++; $display("FAIL p3_rise_edge3: got q%b r%b f%b c%b want q1 r1 f0 c1", d3_o, rise3_o, fall3_o, chg3_o); end
        // Reset while the output is low must restore 1 without a rise pulse.
        d3_i = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({d3_o, rise3_o, fall3_o, chg3_o} !== 4'b1000) begin n_mis++; $display("FAIL p3_reset: got q%b r%b f%b c%b want q1 r0 f0 c0", d3_o, rise3_o, fall3_o, chg3_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        data_i = 8'h00;
        d3_i   = 1'b0;
        test_reset();
        test_latency();
        test_mixed_edges();
        test_random();
        test_mid_reset();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_data_sync
`default_nettype wire
